// File: rtl/key_press_counter_pkg.sv
// Shared types and constants for the pushbutton counter: debounce state
// encoding, key role indices and the debounce timer width.
package key_press_counter_pkg;

  localparam int TIMER_W  = 24;
  localparam int NUM_KEYS = 4;

  localparam int KEY_INC  = 0;
  localparam int KEY_DEC  = 1;
  localparam int KEY_LOAD = 2;
  localparam int KEY_CLR  = 3;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_e;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchronizer followed by a debounce FSM that
// produces a clean pressed level and a single-cycle pulse per accepted press.
module key_debounce
  import key_press_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic pressed_level_o,
  output logic press_pulse_o
);

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               pressed;
  deb_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pulse_q, pulse_d;

  assign pressed = ~sync2_q;

  // NOTE: non-blocking assignments make every flop load from pre-edge values,
  // which is what keeps the two synchronizer stages distinct.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RELEASED;
      timer_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          timer_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = RELEASED;
        end else if (timer_q == TIMER_MAX) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          timer_d = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes the held press without a new pulse.
        if (pressed) begin
          state_d = PRESSED;
        end else if (timer_q == TIMER_MAX) begin
          state_d = RELEASED;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign pressed_level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_pulse_o   = pulse_q;

endmodule

// File: rtl/key_press_counter.sv
// Board top: debounces four pushbuttons and applies clear/load/inc/dec
// commands to a count register displayed on LEDG.
module key_press_counter
  import key_press_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 8
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [7:0]          SW,
  output logic [7:0]          LEDG,
  output logic [NUM_KEYS-1:0] LEDR
);

  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] pressed_level;
  logic [7:0]          sw_sync1_q, sw_sync2_q;
  logic [CNT_W-1:0]    count_q, count_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk            (CLOCK_50),
      .rst            (RESET),
      .key_n_i        (KEY[i]),
      .pressed_level_o(pressed_level[i]),
      .press_pulse_o  (press_pulse[i])
    );
  end

  // Simultaneous inc and dec cancel; clear beats load beats either.
  always_comb begin
    count_d = count_q;
    if (press_pulse[KEY_CLR]) begin
      count_d = '0;
    end else if (press_pulse[KEY_LOAD]) begin
      count_d = CNT_W'(sw_sync2_q);
    end else if (press_pulse[KEY_INC] && !press_pulse[KEY_DEC]) begin
      count_d = count_q + CNT_W'(1);
    end else if (press_pulse[KEY_DEC] && !press_pulse[KEY_INC]) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      count_q    <= '0;
    end else begin
      sw_sync1_q <= SW;
      sw_sync2_q <= sw_sync1_q;
      count_q    <= count_d;
    end
  end

  assign LEDG = count_q[7:0];
  assign LEDR = pressed_level;

endmodule

// File: tb/tb_key_press_counter.sv
// Randomized and directed bench for key_press_counter with a short debounce
// interval, compared every cycle against a run-length reference model.
module tb_key_press_counter;

  localparam int D = 4;

  logic       CLOCK_50;
  logic       RESET;
  logic [3:0] KEY;
  logic [7:0] SW;
  logic [7:0] LEDG;
  logic [3:0] LEDR;

  int checks = 0;
  int errors = 0;

  logic [7:0] cur_sw;

  // Reference model: keys delayed by two samples; a key's level flips once
  // the delayed raw level has disagreed with it for D+1 consecutive samples.
  logic [3:0] m_k1, m_k2;
  logic [7:0] m_sw1, m_sw2;
  int         m_run [4];
  logic [3:0] m_lvl, m_pulse;
  logic [7:0] m_cnt;

  key_press_counter #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .KEY     (KEY),
    .SW      (SW),
    .LEDG    (LEDG),
    .LEDR    (LEDR)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] k, input logic [7:0] s);
    logic [3:0] raw;
    logic [3:0] new_pulse;
    if (r) begin
      m_k1 = 4'hF; m_k2 = 4'hF; m_sw1 = '0; m_sw2 = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_lvl = '0; m_pulse = '0; m_cnt = '0;
    end else begin
      if (m_pulse[3])                m_cnt = 8'h00;
      else if (m_pulse[2])           m_cnt = m_sw2;
      else if (m_pulse[0] && !m_pulse[1]) m_cnt = m_cnt + 8'd1;
      else if (m_pulse[1] && !m_pulse[0]) m_cnt = m_cnt - 8'd1;
      raw = ~m_k2;
      new_pulse = '0;
      for (int i = 0; i < 4; i++) begin
        if (raw[i] == m_lvl[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = raw[i];
            m_run[i] = 0;
            new_pulse[i] = raw[i];
          end
        end
      end
      m_pulse = new_pulse;
      m_k2 = m_k1; m_k1 = k;
      m_sw2 = m_sw1; m_sw1 = s;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] k);
    RESET = r;
    KEY   = k;
    SW    = cur_sw;
    @(posedge CLOCK_50);
    model_edge(r, k, cur_sw);
    #1;
    check("model_ledg", {24'd0, LEDG}, {24'd0, m_cnt});
    check("model_ledr", {28'd0, LEDR}, {28'd0, m_lvl});
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) step(1'b0, k);
  endtask

  // Press the keys in mask long enough to be accepted, then release fully.
  task automatic press(input logic [3:0] mask);
    hold(~mask, D + 4);
    hold(4'hF, D + 6);
  endtask

  initial begin
    cur_sw = 8'h00;
    RESET  = 1'b1;
    KEY    = 4'hF;
    SW     = 8'h00;

    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    check("reset_ledg", {24'd0, LEDG}, 32'h0);
    check("reset_ledr", {28'd0, LEDR}, 32'h0);

    // Latency: KEY[0] low at edge k, level/pulse at k+6, LEDG at k+7.
    hold(4'hE, 6);
    check("latency_ledr_early", {31'd0, LEDR[0]}, 32'h0);
    step(1'b0, 4'hE);
    check("latency_ledr", {31'd0, LEDR[0]}, 32'h1);
    check("latency_ledg_pre", {24'd0, LEDG}, 32'h0);
    step(1'b0, 4'hE);
    check("latency_ledg", {24'd0, LEDG}, 32'h1);
    hold(4'hF, 10);

    // Short glitch is rejected.
    hold(4'hE, 3);
    hold(4'hF, 10);
    check("glitch_ledg", {24'd0, LEDG}, 32'h1);
    check("glitch_ledr", {31'd0, LEDR[0]}, 32'h0);

    // Long hold with bouncy release gives one increment.
    hold(4'hE, 100);
    hold(4'hF, 2);
    hold(4'hE, 2);
    hold(4'hF, 20);
    check("hold_once", {24'd0, LEDG}, 32'h2);

    // Wrap in both directions.
    cur_sw = 8'hFF;
    press(4'b0100);
    check("load_ff", {24'd0, LEDG}, 32'hFF);
    press(4'b0001);
    check("inc_wrap", {24'd0, LEDG}, 32'h00);
    press(4'b0010);
    check("dec_wrap", {24'd0, LEDG}, 32'hFF);

    // Load, clear priority, inc/dec cancellation.
    cur_sw = 8'hA5;
    press(4'b0100);
    check("load_a5", {24'd0, LEDG}, 32'hA5);
    press(4'b1100);
    check("clear_wins", {24'd0, LEDG}, 32'h00);
    press(4'b0100);
    check("reload_a5", {24'd0, LEDG}, 32'hA5);
    press(4'b0011);
    check("inc_dec_cancel", {24'd0, LEDG}, 32'hA5);

    // Reset while KEY[1] is mid-debounce (timer=2), key kept low.
    hold(4'hD, 5);
    step(1'b1, 4'hD);
    check("midreset_ledg", {24'd0, LEDG}, 32'h00);
    check("midreset_ledr", {28'd0, LEDR}, 32'h0);
    hold(4'hD, 5);
    check("midreset_no_early_dec", {24'd0, LEDG}, 32'h00);
    hold(4'hD, 3);
    check("midreset_fresh_dec", {24'd0, LEDG}, 32'hFF);
    hold(4'hF, 10);

    // Randomized segments checked cycle by cycle against the model.
    for (int seg = 0; seg < 300; seg++) begin
      logic [3:0] k;
      int len;
      k   = 4'($urandom);
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 9) == 0) cur_sw = 8'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        step(1'b1, k);
      end else begin
        hold(k, len);
      end
    end
    hold(4'hF, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
